spi_reg_responder: RTL

- SPI slave that answers the 24-bit frames issued by the FPGA's SPI master to the transceiver.
- Decodes each frame into a register-bus read or write and shifts read data back on MISO.
- Used in simulation as the transceiver-side model, and in a loop-back build where a second FPGA region plays the peripheral.
- Fully synchronous to clk; SPI pins are oversampled, never used as clocks.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_reg_responder_if.sv | 33 +++
 rtl/spi_in_sync.sv | 37 +++
 rtl/spi_reg_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register responder: frame geometry,
// FSM state encoding and SPI timing limits.
package spi_pkg;

  localparam int DEF_ADDR_W    = 7;
  localparam int DEF_DATA_W    = 16;
  localparam int SCLK_MIN_HALF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int frame_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  // RWn is the first bit on the wire, i.e. the frame MSB.
  function automatic int rwn_pos(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_reg_responder_if.sv
// SPI pins plus register-bus handshake of the responder, with modports for
// the responder (slave) and the SPI master / register file side (master).
interface spi_reg_responder_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
);

  logic              spi_sclk;
  logic              spi_ss;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_wr;
  logic              reg_rd;
  logic [DATA_W-1:0] reg_rdata;
  logic              frame_done;
  logic              frame_err;

  modport slave (
    input  spi_sclk, spi_ss, spi_mosi, reg_rdata,
    output spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_wr, reg_rd,
           frame_done, frame_err
  );

  modport master (
    output spi_sclk, spi_ss, spi_mosi, reg_rdata,
    input  spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_wr, reg_rd,
           frame_done, frame_err
  );

endinterface

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser for one asynchronous input with one-clk rise and
// fall pulses derived from the synchronised level.
module spi_in_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 slave that turns 24-bit RWn/address/data frames into register
// bus reads and writes; all SPI pins are oversampled on clk.
module spi_reg_responder
  import spi_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_in,
  spi_reg_responder_if.slave  bus
);

  localparam int FRAME_W = frame_width(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  localparam logic [CNT_W-1:0] CNT_HDR_LAST   = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FRAME_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_FRAME      = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT        = CNT_W'(FRAME_W + 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_level;
  logic [1:0] mosi_edges_unused;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst   (reset_in),
    .din   (bus.spi_sclk),
    .level (sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk   (clk),
    .rst   (reset_in),
    .din   (bus.spi_ss),
    .level (ss_level),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst   (reset_in),
    .din   (bus.spi_mosi),
    .level (mosi_level),
    .rise  (mosi_edges_unused[1]),
    .fall  (mosi_edges_unused[0])
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0]  tx_q, tx_d;
  logic               rwn_q, rwn_d;
  logic               load_q, load_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               wr_q, wr_d;
  logic               rd_q, rd_d;
  logic               miso_q, miso_d;
  logic               oe_q, oe_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // An ss rise closes the frame before anything else, so a frame that
  // restarts right after a short ss-high gap still begins cleanly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    rwn_d   = rwn_q;
    load_d  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    miso_d  = miso_q;
    oe_d    = ~ss_level;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (ss_rise) begin
      if (state_q != ST_IDLE) begin
        if (cnt_q == CNT_FRAME) begin
          done_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      state_d = ST_IDLE;
      miso_d  = 1'b0;
    end else if (ss_fall) begin
      state_d = ST_HDR;
      cnt_d   = '0;
      rx_d    = '0;
      tx_d    = '0;
      miso_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
        end
        ST_HDR: begin
          if (sclk_rise) begin
            rx_d  = {rx_q[FRAME_W-2:0], mosi_level};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_HDR_LAST) begin
              rwn_d   = rx_d[ADDR_W];
              addr_d  = rx_d[ADDR_W-1:0];
              rd_d    = rx_d[ADDR_W];
              load_d  = rx_d[ADDR_W];
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          // Read data is captured the clk after reg_rd; the first sclk fall
          // after the header then puts its MSB on the wire.
          if (load_q) begin
            tx_d = bus.reg_rdata;
          end else if (sclk_fall && rwn_q) begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
          if (sclk_rise) begin
            rx_d  = {rx_q[FRAME_W-2:0], mosi_level};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_FRAME_LAST) begin
              if (!rwn_q) begin
                wr_d    = 1'b1;
                wdata_d = rx_d[DATA_W-1:0];
              end
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (sclk_fall) begin
            miso_d = 1'b0;
          end
          if (sclk_rise && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      rwn_q   <= 1'b0;
      load_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      rwn_q   <= rwn_d;
      load_q  <= load_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      miso_q  <= miso_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = oe_q;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wdata   = wdata_q;
  assign bus.reg_wr      = wr_q;
  assign bus.reg_rd      = rd_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_err   = err_q;

endmodule
